// File: rtl/liang_pkg.sv
// Shared core types and constants for the fetch/decode front end.
// Pure declarations; no logic, no latency.
// Not applicable: holds no handshakes.
package liang_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] pc_t;
    typedef logic [31:0]     inst_t;

    // Fetch unit sequencing: one request outstanding at most.
    typedef enum logic [1:0] {
        IFU_IDLE,
        IFU_REQ,
        IFU_WAIT,
        IFU_HOLD
    } ifu_state_e;

    localparam pc_t IFU_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_if.sv
// Bundles the instruction-memory, decode and redirect signals of the fetch unit.
// Wires only; adds no latency.
// Carries valid/ready on the request and decode sides; responses cannot be stalled.
interface ifu_if #(
    parameter int XLEN = liang_pkg::XLEN
);
    // Instruction memory request/response
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_rsp_valid_i;
    logic [31:0]     imem_rsp_data_i;
    logic            imem_rsp_err_i;
    // Decode-side handshake
    logic            inst_valid_o;
    logic            inst_ready_i;
    logic [XLEN-1:0] pc_o;
    logic [31:0]     inst_o;
    logic            inst_err_o;
    // Redirect from branch/jump resolution
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_pc_i;

    // Fetch unit side
    modport master (
        output imem_req_valid_o, imem_req_addr_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
        output inst_valid_o, pc_o, inst_o, inst_err_o,
        input  inst_ready_i,
        input  redirect_valid_i, redirect_pc_i
    );

    // Memory, decode and redirect source side
    modport slave (
        input  imem_req_valid_o, imem_req_addr_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
        input  inst_valid_o, pc_o, inst_o, inst_err_o,
        output inst_ready_i,
        output redirect_valid_i, redirect_pc_i
    );

endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time, presents pc/inst to decode.
// Latency: inst_valid_o rises the cycle after imem_rsp_valid_i; 3-cycle minimum fetch spacing.
// Backpressure: stalls in REQ while memory is not ready and in HOLD until decode takes the word.
module ifu
    import liang_pkg::*;
#(
    parameter int              XLEN     = liang_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    ifu_if.master  bus
);

    ifu_state_e      state_q;
    logic [XLEN-1:0] pc_q;
    logic            drop_q;   // the outstanding response belongs to a redirected-away PC
    inst_t           inst_q;
    logic            err_q;

    logic            misaligned;
    logic [XLEN-1:0] pc_inc_d;

    assign misaligned = (pc_q[1:0] != 2'b00);
    assign pc_inc_d   = pc_q + XLEN'(4);

    // Outputs come only from registered state, so inst_ready_i never reaches imem_*.
    always_comb begin
        bus.imem_req_valid_o = (state_q == IFU_REQ) && !misaligned;
        bus.imem_req_addr_o  = pc_q;
        bus.inst_valid_o     = (state_q == IFU_HOLD);
        bus.pc_o             = pc_q;
        bus.inst_o           = inst_q;
        bus.inst_err_o       = err_q;
    end

    // Fetch sequencing; a redirect overrides every other PC update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IFU_IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IFU_IDLE: begin
                    if (bus.redirect_valid_i) pc_q <= bus.redirect_pc_i;
                    state_q <= IFU_REQ;
                end
                IFU_REQ: begin
                    if (bus.redirect_valid_i) begin
                        pc_q <= bus.redirect_pc_i;
                        // An accepted request is already in flight: mark it stale.
                        if (!misaligned && bus.imem_req_ready_i) begin
                            drop_q  <= 1'b1;
                            state_q <= IFU_WAIT;
                        end
                    end else if (misaligned) begin
                        // Fault without touching memory.
                        inst_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= IFU_HOLD;
                    end else if (bus.imem_req_ready_i) begin
                        state_q <= IFU_WAIT;
                    end
                end
                IFU_WAIT: begin
                    if (bus.imem_rsp_valid_i) begin
                        if (drop_q || bus.redirect_valid_i) begin
                            // Nothing else is outstanding, so the drop flag can clear.
                            if (bus.redirect_valid_i) pc_q <= bus.redirect_pc_i;
                            drop_q  <= 1'b0;
                            state_q <= IFU_REQ;
                        end else begin
                            inst_q  <= bus.imem_rsp_data_i;
                            err_q   <= bus.imem_rsp_err_i;
                            state_q <= IFU_HOLD;
                        end
                    end else if (bus.redirect_valid_i) begin
                        pc_q   <= bus.redirect_pc_i;
                        drop_q <= 1'b1;
                    end
                end
                IFU_HOLD: begin
                    if (bus.redirect_valid_i) begin
                        pc_q    <= bus.redirect_pc_i;
                        state_q <= IFU_REQ;
                    end else if (bus.inst_ready_i) begin
                        pc_q    <= pc_inc_d;
                        state_q <= IFU_REQ;
                    end
                end
                default: state_q <= IFU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for the fetch unit with a behavioural instruction memory.
// Memory accepts on imem_req_ready_i and answers after a programmable delay.
// Bench drives memory ready and decode ready to exercise both stall points.
module tb_ifu;

    logic clk_i;
    logic rst_ni;

    ifu_if bus ();

    ifu dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Memory model controls
    int          rsp_delay;
    logic        force_en;
    logic [31:0] force_dat;
    logic        err_inj;
    int          req_cnt;
    logic        pend_q;
    int          cnt_q;
    logic [31:0] pend_dat;
    logic        pend_err;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0010_0093;
            32'h8000_0004: return 32'h0020_0113;
            32'h8000_0008: return 32'h0030_0193;
            32'h8000_0040: return 32'h0040_0213;
            32'h8000_0100: return 32'h1111_1111;
            default:       return 32'h0000_0013;
        endcase
    endfunction

    // Memory: one response per accepted request, rsp_delay extra cycles late.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q               <= 1'b0;
            cnt_q                <= 0;
            pend_dat             <= '0;
            pend_err             <= 1'b0;
            req_cnt              <= 0;
            bus.imem_rsp_valid_i <= 1'b0;
            bus.imem_rsp_data_i  <= '0;
            bus.imem_rsp_err_i   <= 1'b0;
        end else begin
            bus.imem_rsp_valid_i <= 1'b0;
            if (pend_q) begin
                if (cnt_q == 0) begin
                    bus.imem_rsp_valid_i <= 1'b1;
                    bus.imem_rsp_data_i  <= pend_dat;
                    bus.imem_rsp_err_i   <= pend_err;
                    pend_q               <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 1;
                end
            end
            if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
                req_cnt <= req_cnt + 1;
                if (rsp_delay == 0) begin
                    bus.imem_rsp_valid_i <= 1'b1;
                    bus.imem_rsp_data_i  <= force_en ? force_dat : mem_rd(bus.imem_req_addr_o);
                    bus.imem_rsp_err_i   <= err_inj;
                end else begin
                    pend_q   <= 1'b1;
                    cnt_q    <= rsp_delay - 1;
                    pend_dat <= force_en ? force_dat : mem_rd(bus.imem_req_addr_o);
                    pend_err <= err_inj;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_inst(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.inst_valid_o) break;
            step();
        end
        chk(tag, 32'(bus.inst_valid_o), 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_reqv"}, 32'(bus.imem_req_valid_o), 32'd0);
        chk({tag, "_instv"}, 32'(bus.inst_valid_o), 32'd0);
        chk({tag, "_pc"}, bus.pc_o, 32'h8000_0000);
        chk({tag, "_inst"}, bus.inst_o, 32'h0);
        chk({tag, "_err"}, 32'(bus.inst_err_o), 32'd0);
    endtask

    int rq;

    initial begin
        rst_ni               = 1'b0;
        rsp_delay            = 0;
        force_en             = 1'b0;
        force_dat            = 32'hDEAD_BEEF;
        err_inj              = 1'b0;
        bus.imem_req_ready_i = 1'b1;
        bus.inst_ready_i     = 1'b0;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = '0;

        // Reset state
        step();
        step();
        chk_reset_outs("rst");
        rst_ni = 1'b1;

        // First fetch with zero-wait memory
        step();
        chk("t1_reqv", 32'(bus.imem_req_valid_o), 32'd1);
        chk("t1_addr", bus.imem_req_addr_o, 32'h8000_0000);
        step();
        chk("t1_wait_reqv", 32'(bus.imem_req_valid_o), 32'd0);
        chk("t1_wait_instv", 32'(bus.inst_valid_o), 32'd0);
        step();
        chk("t1_instv", 32'(bus.inst_valid_o), 32'd1);
        chk("t1_pc", bus.pc_o, 32'h8000_0000);
        chk("t1_inst", bus.inst_o, 32'h0010_0093);
        chk("t1_err", 32'(bus.inst_err_o), 32'd0);

        // Consume; memory not ready for 3 cycles
        bus.inst_ready_i     = 1'b1;
        bus.imem_req_ready_i = 1'b0;
        step();
        bus.inst_ready_i = 1'b0;
        chk("t2_instv", 32'(bus.inst_valid_o), 32'd0);
        chk("t2_reqv", 32'(bus.imem_req_valid_o), 32'd1);
        chk("t2_addr", bus.imem_req_addr_o, 32'h8000_0004);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_stall_reqv", 32'(bus.imem_req_valid_o), 32'd1);
            chk("t2_stall_addr", bus.imem_req_addr_o, 32'h8000_0004);
        end
        bus.imem_req_ready_i = 1'b1;
        step();
        step();
        chk("t2_instv", 32'(bus.inst_valid_o), 32'd1);
        chk("t2_pc", bus.pc_o, 32'h8000_0004);
        chk("t2_inst", bus.inst_o, 32'h0020_0113);

        // Decode stalls for 5 cycles
        rq = req_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_instv", 32'(bus.inst_valid_o), 32'd1);
            chk("t3_pc", bus.pc_o, 32'h8000_0004);
            chk("t3_inst", bus.inst_o, 32'h0020_0113);
            chk("t3_reqv", 32'(bus.imem_req_valid_o), 32'd0);
        end
        chk("t3_reqcnt", 32'(req_cnt), 32'(rq));
        bus.imem_req_ready_i = 1'b0;
        bus.inst_ready_i     = 1'b1;
        step();
        bus.inst_ready_i = 1'b0;
        chk("t3_next_reqv", 32'(bus.imem_req_valid_o), 32'd1);
        chk("t3_next_addr", bus.imem_req_addr_o, 32'h8000_0008);

        // Redirect while waiting; late DEADBEEF response must be dropped
        bus.imem_req_ready_i = 1'b1;
        rsp_delay            = 2;
        force_en             = 1'b1;
        step();
        chk("t4_in_wait", 32'(bus.imem_req_valid_o), 32'd0);
        bus.imem_req_ready_i = 1'b0;
        force_en             = 1'b0;
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h8000_0100;
        step();
        bus.redirect_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.imem_req_valid_o) break;
            chk("t4_no_stale", 32'(bus.inst_valid_o), 32'd0);
            step();
        end
        chk("t4_reqv", 32'(bus.imem_req_valid_o), 32'd1);
        chk("t4_addr", bus.imem_req_addr_o, 32'h8000_0100);
        bus.imem_req_ready_i = 1'b1;
        rsp_delay            = 0;
        wait_inst("t4_instv");
        chk("t4_pc", bus.pc_o, 32'h8000_0100);
        chk("t4_inst", bus.inst_o, 32'h1111_1111);

        // Redirect and decode handshake in the same HOLD cycle
        bus.imem_req_ready_i = 1'b0;
        bus.inst_ready_i     = 1'b1;
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h8000_0040;
        step();
        bus.inst_ready_i     = 1'b0;
        bus.redirect_valid_i = 1'b0;
        chk("t5_instv", 32'(bus.inst_valid_o), 32'd0);
        chk("t5_reqv", 32'(bus.imem_req_valid_o), 32'd1);
        chk("t5_addr", bus.imem_req_addr_o, 32'h8000_0040);

        // Bus error, then misaligned redirect target
        err_inj              = 1'b1;
        bus.imem_req_ready_i = 1'b1;
        wait_inst("t6_instv");
        err_inj = 1'b0;
        chk("t6_pc", bus.pc_o, 32'h8000_0040);
        chk("t6_inst", bus.inst_o, 32'h0040_0213);
        chk("t6_err", 32'(bus.inst_err_o), 32'd1);
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h8000_0002;
        step();
        bus.redirect_valid_i = 1'b0;
        rq = req_cnt;
        chk("t6_mis_instv", 32'(bus.inst_valid_o), 32'd0);
        chk("t6_mis_reqv", 32'(bus.imem_req_valid_o), 32'd0);
        step();
        chk("t6_mis_hold", 32'(bus.inst_valid_o), 32'd1);
        chk("t6_mis_pc", bus.pc_o, 32'h8000_0002);
        chk("t6_mis_inst", bus.inst_o, 32'h0);
        chk("t6_mis_err", 32'(bus.inst_err_o), 32'd1);
        chk("t6_mis_noreq", 32'(req_cnt), 32'(rq));

        // Asynchronous reset in WAIT
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h8000_0008;
        rsp_delay            = 2;
        step();
        bus.redirect_valid_i = 1'b0;
        chk("t7_addr", bus.imem_req_addr_o, 32'h8000_0008);
        step();
        chk("t7_in_wait", 32'(bus.imem_req_valid_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        chk_reset_outs("t7_arst");
        step();
        step();
        rsp_delay = 0;
        rst_ni    = 1'b1;
        step();
        chk("t7_restart_reqv", 32'(bus.imem_req_valid_o), 32'd1);
        chk("t7_restart_addr", bus.imem_req_addr_o, 32'h8000_0000);
        wait_inst("t7_instv");
        chk("t7_pc", bus.pc_o, 32'h8000_0000);
        chk("t7_inst", bus.inst_o, 32'h0010_0093);
        chk("t7_err", 32'(bus.inst_err_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
